fp_add_arbiter: RTL

- Shares one pipelined fp_add instance between N_REQ requesters, such as the convolution accumulator lanes.
- Each cycle, a round-robin grant picks one pending operand pair and issues it to the adder.
- A tag pipeline records which requester owns each in-flight operation, and each result is routed back to that requester.
- The block sits between the lane controllers and an externally instantiated fp_add, whose ports connect directly to this block's add_* ports.

---
 rtl/fp_add_arbiter_if.sv | 28 ++
 rtl/fp_add_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/fp_add_arbiter_if.sv
// Handshake bundle between the lane controllers, the arbiter and the shared fp_add.
// master: requester/adder side; slave: the arbiter itself.
interface fp_add_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_dataa;
    logic [N_REQ*WIDTH-1:0] req_datab;
    logic [N_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]       resp_result;
    logic                   add_valid;
    logic [WIDTH-1:0]       add_dataa;
    logic [WIDTH-1:0]       add_datab;
    logic                   add_result_valid;
    logic [WIDTH-1:0]       add_result;

    modport master (
        output req_valid, req_dataa, req_datab, add_result_valid, add_result,
        input  req_ready, resp_valid, resp_result, add_valid, add_dataa, add_datab
    );

    modport slave (
        input  req_valid, req_dataa, req_datab, add_result_valid, add_result,
        output req_ready, resp_valid, resp_result, add_valid, add_dataa, add_datab
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one fixed-latency fp_add between N_REQ requesters,
// with a tag pipeline that routes each result back to its owner.
module fp_add_arbiter #(
    parameter int N_REQ       = 4,
    parameter int EXP         = 8,
    parameter int MANT        = 23,
    parameter int WIDTH       = EXP + MANT + 1,
    parameter int ADD_LATENCY = 3,
    parameter int TAGW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                              clock,
    input  logic                              clock_sreset,
    input  logic                              enable,
    fp_add_arbiter_if.slave                   bus,
    output logic [$clog2(ADD_LATENCY+2):0]    inflight,
    output logic                              idle,
    output logic                              error
);
    logic [TAGW-1:0]        ptr;
    logic [TAGW-1:0]        grant_idx;
    logic                   grant_found;
    logic                   transfer;
    logic [N_REQ-1:0]       ready;
    logic [TAGW-1:0]        issue_tag;
    logic [ADD_LATENCY-1:0] tag_v;
    logic [TAGW-1:0]        tag_t [ADD_LATENCY];
    logic                   tail_v;
    logic [N_REQ-1:0]       tail_onehot;

    // Search starts just above the last granted requester and wraps.
    always_comb begin
        int              cand;
        logic [TAGW-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        ready       = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ)
                cand = cand - N_REQ;
            cand_idx = TAGW'(cand);
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        if (enable && grant_found)
            ready[grant_idx] = 1'b1;
    end

    assign bus.req_ready = ready;
    assign transfer      = enable && grant_found;

    assign tail_v = tag_v[ADD_LATENCY-1];

    always_comb begin
        tail_onehot = '0;
        tail_onehot[tag_t[ADD_LATENCY-1]] = 1'b1;
    end

    assign idle = (inflight == '0) && !(|bus.req_valid);

    // The {add_valid, issue_tag} pair is stage zero; the shift register adds
    // ADD_LATENCY more so the tail lines up with add_result_valid.
    always_ff @(posedge clock or posedge clock_sreset) begin
        if (clock_sreset) begin
            ptr             <= TAGW'(N_REQ - 1);
            bus.add_valid   <= 1'b0;
            bus.add_dataa   <= '0;
            bus.add_datab   <= '0;
            issue_tag       <= '0;
            tag_v           <= '0;
            for (int k = 0; k < ADD_LATENCY; k++)
                tag_t[k] <= '0;
            bus.resp_valid  <= '0;
            bus.resp_result <= '0;
            inflight        <= '0;
            error           <= 1'b0;
        end else begin
            bus.add_valid <= transfer;
            if (transfer) begin
                ptr           <= grant_idx;
                issue_tag     <= grant_idx;
                bus.add_dataa <= bus.req_dataa[grant_idx*WIDTH +: WIDTH];
                bus.add_datab <= bus.req_datab[grant_idx*WIDTH +: WIDTH];
            end

            tag_v[0] <= bus.add_valid;
            tag_t[0] <= issue_tag;
            for (int k = 1; k < ADD_LATENCY; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_t[k] <= tag_t[k-1];
            end

            if (bus.add_result_valid && tail_v) begin
                bus.resp_valid  <= tail_onehot;
                bus.resp_result <= bus.add_result;
            end else begin
                bus.resp_valid  <= '0;
            end

            // A dropped operation (tail valid, no result) still leaves the count.
            case ({transfer, tail_v})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            if (bus.add_result_valid != tail_v)
                error <= 1'b1;
        end
    end
endmodule
